// File: rtl/serial_frame_receiver.sv
// Serial frame receiver: start bit, 6 data bits LSB first (bit5 = parity), stop bit.
// Hands complete frames to the downstream parity checker through a valid/ack holding register.
module serial_frame_receiver #(
  parameter int unsigned CLKS_PER_BIT = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [5:0] frame_data,
  output logic       frame_valid,
  input  logic       frame_ack,
  output logic       framing_err,
  output logic       overrun
);

  localparam int unsigned CntW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CntW-1:0] CntHalf = CntW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CntW-1:0] CntLast = CntW'(CLKS_PER_BIT - 1);
  localparam logic [2:0] IdxLast = 3'd5;

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StStop,
    StWaitHi
  } state_e;

  state_e          state_q, state_d;
  logic            sync1_q, sync1_d;
  logic            sync2_q, sync2_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [2:0]      idx_q, idx_d;
  logic [5:0]      shift_q, shift_d;
  logic [5:0]      data_q, data_d;
  logic            valid_q, valid_d;
  logic            ferr_q, ferr_d;
  logic            ovr_q, ovr_d;
  logic            rx_s;

  assign rx_s = sync2_q;

  always_comb begin
    sync1_d = rx;
    sync2_d = sync1_q;
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    shift_d = shift_q;
    data_d  = data_q;
    valid_d = valid_q;
    ferr_d  = 1'b0;
    ovr_d   = 1'b0;

    // A plain ack retires the held frame; a delivery at the same edge overrides below.
    if (frame_ack && valid_q) begin
      valid_d = 1'b0;
    end

    unique case (state_q)
      StIdle: begin
        cnt_d = '0;
        if (!rx_s) begin
          state_d = StStart;
        end
      end
      StStart: begin
        if (cnt_q == CntHalf) begin
          cnt_d   = '0;
          idx_d   = '0;
          state_d = rx_s ? StIdle : StData;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StData: begin
        if (cnt_q == CntLast) begin
          cnt_d   = '0;
          shift_d = {rx_s, shift_q[5:1]};
          idx_d   = idx_q + 3'd1;
          if (idx_q == IdxLast) begin
            state_d = StStop;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StStop: begin
        if (cnt_q == CntLast) begin
          cnt_d = '0;
          if (rx_s) begin
            state_d = StIdle;
            if (!valid_q || frame_ack) begin
              data_d  = shift_q;
              valid_d = 1'b1;
            end else begin
              ovr_d = 1'b1;
            end
          end else begin
            ferr_d  = 1'b1;
            state_d = StWaitHi;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StWaitHi: begin
        // A held-low line (break) must return high before a new start is accepted.
        cnt_d = '0;
        if (rx_s) begin
          state_d = StIdle;
        end
      end
      default: begin
        state_d = StIdle;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      state_q <= StIdle;
      cnt_q   <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
      ovr_q   <= ovr_d;
    end
  end

  assign frame_data  = data_q;
  assign frame_valid = valid_q;
  assign framing_err = ferr_q;
  assign overrun     = ovr_q;

  err_pulses_exclusive: assert property (@(posedge clk) disable iff (rst)
    !(framing_err && overrun));

endmodule

// File: tb/tb_serial_frame_receiver.sv
// Bench for serial_frame_receiver: transaction-level model (frame outcome at start+62 edges,
// valid/ack holding rules) compared every cycle, plus literal checks on the directed cases.
module tb_serial_frame_receiver;

  localparam int unsigned C = 8;
  localparam int StopOfs = 2 + C / 2 + 7 * C;  // 62: edge of the stop sample after the start fall

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx = 1'b0;
  logic       frame_ack = 1'b0;
  logic [5:0] frame_data;
  logic       frame_valid;
  logic       framing_err;
  logic       overrun;

  serial_frame_receiver #(.CLKS_PER_BIT(C)) dut (
    .clk        (clk),
    .rst        (rst),
    .rx         (rx),
    .frame_data (frame_data),
    .frame_valid(frame_valid),
    .frame_ack  (frame_ack),
    .framing_err(framing_err),
    .overrun    (overrun)
  );

  initial forever #5 clk = ~clk;

  int         edge_n = 0;
  int         n_checks = 0;
  int         n_pass = 0;
  bit         model_live = 1'b0;
  logic [5:0] m_data = '0;
  bit         m_valid = 1'b0;
  bit         m_ferr = 1'b0;
  bit         m_ovr = 1'b0;
  int         ev_kind[int];  // 1 = good frame ends, 2 = stop bit low
  logic [5:0] ev_data[int];
  bit         rand_ack_en = 1'b0;
  bit         ack_dir = 1'b0;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (edge %0d)", name, act, exp, edge_n);
  endtask

  // Expected outputs after each edge, from the scheduled frame outcomes and the handshake rules.
  initial forever begin
    @(posedge clk);
    edge_n++;
    if (rst) begin
      model_live = 1'b1;
      m_data = '0;
      m_valid = 1'b0;
      m_ferr = 1'b0;
      m_ovr = 1'b0;
      ev_kind.delete();
      ev_data.delete();
    end else begin
      m_ferr = 1'b0;
      m_ovr = 1'b0;
      if (ev_kind.exists(edge_n)) begin
        if (ev_kind[edge_n] == 1) begin
          if (!m_valid || frame_ack) begin
            m_data = ev_data[edge_n];
            m_valid = 1'b1;
          end else begin
            m_ovr = 1'b1;
          end
        end else begin
          m_ferr = 1'b1;
        end
        ev_kind.delete(edge_n);
      end else if (frame_ack && m_valid) begin
        m_valid = 1'b0;
      end
    end
  end

  initial forever begin
    @(negedge clk);
    if (model_live) begin
      chk("frame_valid", {7'd0, frame_valid}, {7'd0, m_valid});
      chk("frame_data", {2'd0, frame_data}, {2'd0, m_data});
      chk("framing_err", {7'd0, framing_err}, {7'd0, m_ferr});
      chk("overrun", {7'd0, overrun}, {7'd0, m_ovr});
    end
  end

  initial forever begin
    @(posedge clk);
    #2;
    frame_ack = rand_ack_en ? ($urandom_range(0, 3) == 0) : ack_dir;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: time limit reached at edge %0d", edge_n);
    $fatal(1, "watchdog");
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic goto_edge(input int e);
    while (edge_n < e) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic at_edge(input int e);
    goto_edge(e);
    @(negedge clk);
  endtask

  task automatic ack_pulse();
    ack_dir = 1'b1;
    step(1);
    ack_dir = 1'b0;
  endtask

  // Drives one frame starting now; rx falls before edge t, outcome is due at edge t+62.
  task automatic send_frame(input logic [5:0] d, input bit stop_hi, input int hold_lo,
                            input int gap);
    int t;
    t = edge_n + 1;
    ev_kind[t + StopOfs] = stop_hi ? 1 : 2;
    ev_data[t + StopOfs] = d;
    rx = 1'b0;
    step(C);
    for (int i = 0; i < 6; i++) begin
      rx = d[i];
      step(C);
    end
    rx = stop_hi;
    step(C);
    if (!stop_hi) begin
      step(hold_lo);
      rx = 1'b1;
    end
    step(gap);
  endtask

  initial begin
    int t;
    int r;
    // 1: reset with rx low, then idle line
    rst = 1'b1;
    rx = 1'b0;
    step(3);
    rst = 1'b0;
    rx = 1'b1;
    chk("rst_valid", {7'd0, frame_valid}, 8'd0);
    chk("rst_data", {2'd0, frame_data}, 8'd0);
    chk("rst_ferr", {7'd0, framing_err}, 8'd0);
    chk("rst_ovr", {7'd0, overrun}, 8'd0);
    step(100);
    chk("idle_valid", {7'd0, frame_valid}, 8'd0);

    // 2: single good frame, held without ack, then acked
    t = edge_n + 1;
    fork
      send_frame(6'b010110, 1'b1, 0, 0);
      begin
        at_edge(t + 61);
        chk("t2_before_stop", {7'd0, frame_valid}, 8'd0);
        at_edge(t + 62);
        chk("t2_valid", {7'd0, frame_valid}, 8'd1);
        chk("t2_data", {2'd0, frame_data}, 8'h16);
      end
    join
    step(20);
    chk("t2_hold", {7'd0, frame_valid}, 8'd1);
    ack_pulse();
    chk("t2_acked", {7'd0, frame_valid}, 8'd0);

    // 3: short glitch
    rx = 1'b0;
    step(2);
    rx = 1'b1;
    step(100);
    chk("t3_valid", {7'd0, frame_valid}, 8'd0);

    // 4: stop bit low, line held low, then a normal frame
    t = edge_n + 1;
    fork
      send_frame(6'b111111, 1'b0, 40, 5);
      begin
        at_edge(t + 62);
        chk("t4_ferr", {7'd0, framing_err}, 8'd1);
        chk("t4_valid", {7'd0, frame_valid}, 8'd0);
        at_edge(t + 63);
        chk("t4_ferr_end", {7'd0, framing_err}, 8'd0);
      end
    join
    t = edge_n + 1;
    fork
      send_frame(6'b000001, 1'b1, 0, 3);
      begin
        at_edge(t + 62);
        chk("t4_next_data", {2'd0, frame_data}, 8'h01);
      end
    join
    ack_pulse();

    // 5: back-to-back, no ack -> overrun; then ack exactly at the second stop edge
    send_frame(6'b000001, 1'b1, 0, 0);
    t = edge_n + 1;
    fork
      send_frame(6'b100000, 1'b1, 0, 2);
      begin
        at_edge(t + 62);
        chk("t5_ovr", {7'd0, overrun}, 8'd1);
        chk("t5_keep_data", {2'd0, frame_data}, 8'h01);
        at_edge(t + 63);
        chk("t5_ovr_end", {7'd0, overrun}, 8'd0);
      end
    join
    ack_pulse();
    send_frame(6'b000001, 1'b1, 0, 0);
    t = edge_n + 1;
    fork
      send_frame(6'b100000, 1'b1, 0, 2);
      begin
        goto_edge(t + 61);
        ack_dir = 1'b1;
        goto_edge(t + 62);
        ack_dir = 1'b0;
        @(negedge clk);
        chk("t5b_data", {2'd0, frame_data}, 8'h20);
        chk("t5b_valid", {7'd0, frame_valid}, 8'd1);
        chk("t5b_no_ovr", {7'd0, overrun}, 8'd0);
      end
    join
    ack_pulse();

    // 6: reset mid-frame with a frame pending, then a clean frame
    send_frame(6'b101010, 1'b1, 0, 2);
    rx = 1'b0;
    step(C);
    rx = 1'b1;
    step(C);
    rx = 1'b0;
    step(C);
    rx = 1'b1;
    step(C + C / 2);
    rst = 1'b1;
    step(2);
    chk("t6_rst_valid", {7'd0, frame_valid}, 8'd0);
    chk("t6_rst_data", {2'd0, frame_data}, 8'd0);
    rst = 1'b0;
    step(10);
    t = edge_n + 1;
    fork
      send_frame(6'b010101, 1'b1, 0, 2);
      begin
        at_edge(t + 62);
        chk("t6_data", {2'd0, frame_data}, 8'h15);
        chk("t6_valid", {7'd0, frame_valid}, 8'd1);
      end
    join
    ack_pulse();

    // Random traffic with random acks
    rand_ack_en = 1'b1;
    for (int k = 0; k < 40; k++) begin
      r = $urandom_range(0, 99);
      if (r < 70) begin
        send_frame(6'($urandom), 1'b1, 0, $urandom_range(0, 6));
      end else if (r < 85) begin
        send_frame(6'($urandom), 1'b0, $urandom_range(0, 30), $urandom_range(2, 6));
      end else begin
        rx = 1'b0;
        step($urandom_range(1, 2));
        rx = 1'b1;
        step($urandom_range(8, 12));
      end
    end
    rand_ack_en = 1'b0;
    step(20);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
